// File: rtl/ktms_cmd_fetch_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ktms_cmd_fetch_sched_pkg
// Brief    : Shared defaults and helpers for the command-fetch scheduler.
// Revision : 1.0  initial release
// ============================================================================
package ktms_cmd_fetch_sched_pkg;

  // Default geometry: four requesters, four outstanding fetch tags, 6-bit counters
  localparam int KTMS_NREQ_DEF  = 4;
  localparam int KTMS_ID_W_DEF  = 2;
  localparam int KTMS_TAG_W_DEF = 2;
  localparam int KTMS_CNT_W_DEF = 6;

  // Next round-robin start position after a winner at idx, wrapping at n
  function automatic int ktms_wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ktms_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ktms_rr_pick
// Brief    : Combinational round-robin picker. The lowest requesting index at
//            or after i_ptr wins, wrapping around to index 0. Tying i_ptr to 0
//            makes it a plain lowest-set-bit finder.
// Revision : 1.0  initial release
// ============================================================================
module ktms_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // First pass covers indices at or above the pointer, second pass wraps to 0
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ktms_cmd_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module   : ktms_cmd_fetch_sched
// Brief    : Counts per-requester doorbells, arbitrates them round-robin into
//            one fetch-request stream with a tag per outstanding fetch, and
//            maps completion beats back to their requester.
// Revision : 1.0  initial release
// ============================================================================
module ktms_cmd_fetch_sched
  import ktms_cmd_fetch_sched_pkg::*;
#(
  parameter int NREQ      = KTMS_NREQ_DEF,
  parameter int ID_WIDTH  = KTMS_ID_W_DEF,
  parameter int TAG_WIDTH = KTMS_TAG_W_DEF,
  parameter int CNT_WIDTH = KTMS_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      i_db_v,
  input  logic [NREQ-1:0]      i_en,
  output logic                 o_req_v,
  input  logic                 i_req_r,
  output logic [ID_WIDTH-1:0]  o_req_id,
  output logic [TAG_WIDTH-1:0] o_req_tag,
  input  logic                 i_cpl_v,
  input  logic [TAG_WIDTH-1:0] i_cpl_tag,
  input  logic                 i_cpl_e,
  output logic [ID_WIDTH-1:0]  o_cpl_id,
  output logic [NREQ-1:0]      o_ovf,
  output logic                 o_perror,
  output logic                 o_idle
);

  localparam int                   c_ntags   = 1 << TAG_WIDTH;
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  logic [CNT_WIDTH-1:0] r_cnt     [NREQ];
  logic [CNT_WIDTH-1:0] w_cnt_nxt [NREQ];
  logic [NREQ-1:0]      w_ovf_set;
  logic [NREQ-1:0]      r_ovf;
  logic [ID_WIDTH-1:0]  r_ptr;

  logic [c_ntags-1:0]   r_busy;
  logic [c_ntags-1:0]   w_busy_nxt;
  logic [ID_WIDTH-1:0]  r_tag_id [c_ntags];

  logic                 r_req_v;
  logic [ID_WIDTH-1:0]  r_req_id;
  logic [TAG_WIDTH-1:0] r_req_tag;
  logic                 r_perror;
  logic                 r_idle;

  logic [NREQ-1:0]      w_elig;
  logic [NREQ-1:0]      w_win_oh;
  logic [ID_WIDTH-1:0]  w_win_idx;
  logic                 w_win_any;
  logic [c_ntags-1:0]   w_tag_oh;
  logic [TAG_WIDTH-1:0] w_tag_idx;
  logic                 w_tag_any;

  logic                 w_accept;
  logic                 w_slot_open;
  logic                 w_load;
  logic [NREQ-1:0]      w_grant;
  logic                 w_cpl_free;
  logic                 w_cpl_bad;
  logic                 w_req_v_nxt;
  logic                 w_idle_nxt;

  // Requesters compete only while enabled and holding pending commands
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = i_en[i] & (r_cnt[i] != '0);
    end
  end

  ktms_rr_pick #(.N(NREQ), .W(ID_WIDTH)) u_req_pick (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_win_oh),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  // Tag choice uses pre-edge busy bits, so a tag freed this cycle is never reused this cycle
  ktms_rr_pick #(.N(c_ntags), .W(TAG_WIDTH)) u_tag_pick (
    .i_req (~r_busy),
    .i_ptr ('0),
    .o_gnt (w_tag_oh),
    .o_idx (w_tag_idx),
    .o_any (w_tag_any)
  );

  // Slot load decision plus completion classification
  always_comb begin
    w_accept    = r_req_v & i_req_r;
    w_slot_open = ~r_req_v | w_accept;
    w_load      = w_slot_open & w_tag_any & w_win_any;
    w_grant     = w_load ? w_win_oh : '0;
    w_cpl_free  = i_cpl_v & i_cpl_e & r_busy[i_cpl_tag];
    w_cpl_bad   = i_cpl_v & ~r_busy[i_cpl_tag];
    w_req_v_nxt = w_load | (r_req_v & ~i_req_r);
  end

  // Pending counters: doorbell +1, grant -1, saturate at all-ones and flag the lost doorbell
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_ovf_set[i] = 1'b0;
      if (!i_en[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (i_db_v[i] && !w_grant[i]) begin
        if (r_cnt[i] == c_cnt_max) begin
          w_ovf_set[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end else if (!i_db_v[i] && w_grant[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
      end
    end
  end

  // Tag busy bits after this edge and the resulting idle indication
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_cpl_free) begin
      w_busy_nxt[i_cpl_tag] = 1'b0;
    end
    if (w_load) begin
      w_busy_nxt = w_busy_nxt | w_tag_oh;
    end
    w_idle_nxt = ~w_req_v_nxt & (w_busy_nxt == '0);
    for (int i = 0; i < NREQ; i++) begin
      if (w_cnt_nxt[i] != '0) begin
        w_idle_nxt = 1'b0;
      end
    end
  end

  // State registers: counters, tag table, request slot, RR pointer and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
      for (int t = 0; t < c_ntags; t++) begin
        r_tag_id[t] <= '0;
      end
      r_ovf     <= '0;
      r_ptr     <= '0;
      r_busy    <= '0;
      r_req_v   <= 1'b0;
      r_req_id  <= '0;
      r_req_tag <= '0;
      r_perror  <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_ovf    <= r_ovf | w_ovf_set;
      r_perror <= r_perror | w_cpl_bad;
      r_busy   <= w_busy_nxt;
      r_req_v  <= w_req_v_nxt;
      r_idle   <= w_idle_nxt;
      if (w_load) begin
        r_tag_id[w_tag_idx] <= w_win_idx;
        r_req_id            <= w_win_idx;
        r_req_tag           <= w_tag_idx;
        r_ptr               <= ID_WIDTH'(ktms_wrap_inc(int'(w_win_idx), NREQ));
      end
    end
  end

  assign o_req_v   = r_req_v;
  assign o_req_id  = r_req_id;
  assign o_req_tag = r_req_tag;
  assign o_cpl_id  = r_tag_id[i_cpl_tag];
  assign o_ovf     = r_ovf;
  assign o_perror  = r_perror;
  assign o_idle    = r_idle;

endmodule
`default_nettype wire
